// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt controller.
package interrupt_pkg;
   localparam int IRQ_IDX_W = 3;
   localparam logic [15:0] IRQ_VECTOR_BASE = 16'h0040;

   typedef enum logic [IRQ_IDX_W-1:0] {
      IRQ_VBLANK = 3'd0,
      IRQ_STAT   = 3'd1,
      IRQ_TIMER  = 3'd2,
      IRQ_SERIAL = 3'd3,
      IRQ_JOYPAD = 3'd4
   } irq_idx_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } irq_state_e;

   // Each source owns an 8-byte slot above the vector base.
   function automatic logic [15:0] irq_vector_of(input logic [IRQ_IDX_W-1:0] idx);
      return IRQ_VECTOR_BASE + {10'd0, idx, 3'b000};
   endfunction
endpackage

// File: rtl/mmu_addresses_pkg.sv
// Memory-mapped register addresses shared by CPU-side peripherals.
package mmu_addresses_pkg;
   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;
endpackage

// File: rtl/bus_if.sv
// CPU register port: byte-wide read/write bus with combinational read data.
interface Bus_if;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        write_en;
   logic        read_en;
   logic [7:0]  rdata;

   modport Peripheral_side (input addr, input wdata, input write_en, input read_en, output rdata);
   modport Cpu_side        (output addr, output wdata, output write_en, output read_en, input rdata);
endinterface

// File: rtl/irq_priority_encoder.sv
// Lowest-numbered set bit of the mask wins.
module irq_priority_encoder #(
   parameter int NUM_IRQ = 5,
   parameter int IDX_W   = 3
) (
   input  logic [NUM_IRQ-1:0] mask,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (mask[i]) begin
            valid = 1'b1;
            index = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/interrupt_controller.sv
// Interrupt flag/enable registers with a two-state dispatch handshake to the CPU.
//   state    | meaning
//   ST_IDLE  | waiting for irq_ack; vector holds last dispatch target
//   ST_GRANT | dispatch in progress; vector frozen until irq_done
module interrupt_controller
   import interrupt_pkg::*;
   import mmu_addresses_pkg::*;
#(
   parameter int NUM_IRQ = 5
) (
   input  logic               clk,
   input  logic               reset,
   Bus_if.Peripheral_side     bus,
   input  logic [NUM_IRQ-1:0] irq_req,
   output logic               irq_pending,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic [15:0]        irq_vector,
   output logic               irq_busy
);
   irq_state_e         r_state;
   logic [NUM_IRQ-1:0] r_if;
   logic [7:0]         r_ie;
   logic [15:0]        r_vector;

   logic [NUM_IRQ-1:0]   w_enabled;
   logic [NUM_IRQ-1:0]   w_clr_mask;
   logic [NUM_IRQ-1:0]   w_if_next;
   logic [7:0]           w_if_byte;
   logic [15:0]          w_win_vector;
   logic [IRQ_IDX_W-1:0] w_win_idx;
   logic                 w_win_valid;
   logic                 w_sel_if;
   logic                 w_sel_ie;
   logic                 w_dispatch;

   assign w_enabled  = r_if & r_ie[NUM_IRQ-1:0];
   assign w_sel_if   = (bus.addr == ADDR_IF);
   assign w_sel_ie   = (bus.addr == ADDR_IE);
   assign w_dispatch = (r_state == ST_IDLE) && irq_ack;

   irq_priority_encoder #(
      .NUM_IRQ (NUM_IRQ),
      .IDX_W   (IRQ_IDX_W)
   ) u_prio (
      .mask  (w_enabled),
      .valid (w_win_valid),
      .index (w_win_idx)
   );

   // An ack with nothing enabled still grants, but with a null vector.
   assign w_win_vector = w_win_valid ? irq_vector_of(w_win_idx) : 16'h0000;

   always_comb begin
      w_clr_mask = '0;
      if (w_dispatch && w_win_valid) w_clr_mask[w_win_idx] = 1'b1;
   end

   // New requests are OR-ed last so they beat both the ack clear and a bus write.
   assign w_if_next = ((bus.write_en && w_sel_if) ? bus.wdata[NUM_IRQ-1:0]
                                                  : (r_if & ~w_clr_mask)) | irq_req;

   always_comb begin
      w_if_byte = 8'hFF;
      w_if_byte[NUM_IRQ-1:0] = r_if;
   end

   always_comb begin
      bus.rdata = 8'hFF;
      if (bus.read_en) begin
         if (w_sel_if)      bus.rdata = w_if_byte;
         else if (w_sel_ie) bus.rdata = r_ie;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_if     <= '0;
         r_ie     <= 8'h00;
         r_vector <= 16'h0000;
      end else begin
         r_if <= w_if_next;
         if (bus.write_en && w_sel_ie) r_ie <= bus.wdata;
         case (r_state)
            ST_IDLE: begin
               if (irq_ack) begin
                  r_vector <= w_win_vector;
                  r_state  <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (irq_done) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign irq_pending = |w_enabled;
   assign irq_vector  = r_vector;
   assign irq_busy    = (r_state == ST_GRANT);
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller against a behavioural flag/enable model.
module tb_interrupt_controller;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  irq_req;
   logic        irq_ack;
   logic        irq_done;
   logic        irq_pending;
   logic        irq_busy;
   logic [15:0] irq_vector;

   Bus_if bus_i ();

   always #5 clk = ~clk;

   interrupt_controller #(.NUM_IRQ(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_i),
      .irq_req     (irq_req),
      .irq_pending (irq_pending),
      .irq_ack     (irq_ack),
      .irq_done    (irq_done),
      .irq_vector  (irq_vector),
      .irq_busy    (irq_busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: flags as a bit array, enable byte, dispatch flag, latched vector.
   bit       m_if[5];
   bit [7:0] m_ie;
   bit       m_grant;
   int       m_vec;

   function automatic int m_winner();
      for (int k = 0; k < 5; k++)
         if (m_if[k] && m_ie[k]) return k;
      return -1;
   endfunction

   function automatic int m_rdata(input int addr, input bit re);
      int v;
      if (!re) return 255;
      if (addr == 16'hFF0F) begin
         v = 224;
         for (int k = 0; k < 5; k++) if (m_if[k]) v += (1 << k);
         return v;
      end
      if (addr == 16'hFFFF) return int'(m_ie);
      return 255;
   endfunction

   task automatic m_step(input bit rst, input bit [4:0] req, input bit ack, input bit done,
                         input bit we, input int addr, input bit [7:0] wd);
      int clr;
      int w;
      clr = -1;
      if (rst) begin
         for (int k = 0; k < 5; k++) m_if[k] = 0;
         m_ie = 0; m_grant = 0; m_vec = 0;
         return;
      end
      if (!m_grant && ack) begin
         w = m_winner();
         m_vec = (w < 0) ? 0 : 64 + 8 * w;
         clr = w;
         m_grant = 1;
      end else if (m_grant && done) begin
         m_grant = 0;
      end
      for (int k = 0; k < 5; k++) begin
         if (req[k])                     m_if[k] = 1;
         else if (we && addr == 16'hFF0F) m_if[k] = wd[k];
         else if (k == clr)              m_if[k] = 0;
      end
      if (we && addr == 16'hFFFF) m_ie = wd;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit rst, input bit [4:0] req, input bit ack, input bit done,
                        input bit we, input bit re, input logic [15:0] addr, input logic [7:0] wd);
      int m_pend;
      reset = rst; irq_req = req; irq_ack = ack; irq_done = done;
      bus_i.write_en = we; bus_i.read_en = re; bus_i.addr = addr; bus_i.wdata = wd;
      #1;
      chk("rdata", int'(bus_i.rdata), m_rdata(int'(addr), re));
      @(posedge clk);
      m_step(rst, req, ack, done, we, int'(addr), wd);
      #1;
      m_pend = (m_winner() >= 0) ? 1 : 0;
      chk("irq_pending", int'(irq_pending), m_pend);
      chk("irq_busy", int'(irq_busy), int'(m_grant));
      chk("irq_vector", int'(irq_vector), m_vec);
      reset = 0; irq_req = '0; irq_ack = 0; irq_done = 0;
      bus_i.write_en = 0; bus_i.read_en = 0;
   endtask

   task automatic idle();                   cycle(0, 5'b0, 0, 0, 0, 0, 16'h0000, 8'h00); endtask
   task automatic wr(input logic [15:0] a, input logic [7:0] d); cycle(0, 5'b0, 0, 0, 1, 0, a, d); endtask
   task automatic pulse_req(input bit [4:0] r); cycle(0, r, 0, 0, 0, 0, 16'h0000, 8'h00); endtask
   task automatic ack();                    cycle(0, 5'b0, 1, 0, 0, 0, 16'h0000, 8'h00); endtask
   task automatic done();                   cycle(0, 5'b0, 0, 1, 0, 0, 16'h0000, 8'h00); endtask

   // Combinational read without a clock edge, checked against a hand-computed literal.
   task automatic peek(input string name, input logic [15:0] a, input logic [7:0] exp);
      bus_i.addr = a; bus_i.read_en = 1;
      #1;
      chk(name, int'(bus_i.rdata), int'(exp));
      bus_i.read_en = 0;
   endtask

   initial begin
      reset = 1; irq_req = '0; irq_ack = 0; irq_done = 0;
      bus_i.addr = '0; bus_i.wdata = '0; bus_i.write_en = 0; bus_i.read_en = 0;
      m_ie = 0; m_grant = 0; m_vec = 0;
      for (int k = 0; k < 5; k++) m_if[k] = 0;

      cycle(1, 5'b0, 0, 0, 0, 0, 16'h0000, 8'h00);
      cycle(1, 5'b11111, 1, 0, 1, 0, 16'hFF0F, 8'hFF);
      chk("reset busy", int'(irq_busy), 0);
      chk("reset vector", int'(irq_vector), 16'h0000);
      peek("reset IF read", 16'hFF0F, 8'hE0);

      // Timer request latency and IF readback
      wr(16'hFFFF, 8'h04);
      pulse_req(5'b00100);
      chk("timer pending N+1", int'(irq_pending), 1);
      peek("IF after timer", 16'hFF0F, 8'hE4);
      cycle(0, 5'b0, 0, 0, 0, 1, 16'hFF0F, 8'h00);

      // Dispatch picks the lowest enabled bit
      wr(16'hFFFF, 8'h1F);
      wr(16'hFF0F, 8'h16);
      done();
      ack();
      chk("STAT vector", int'(irq_vector), 16'h0048);
      chk("STAT busy", int'(irq_busy), 1);
      peek("IF after STAT ack", 16'hFF0F, 8'hF4);
      ack();
      chk("ack ignored in GRANT", int'(irq_vector), 16'h0048);
      peek("IF held in GRANT", 16'hFF0F, 8'hF4);
      done();
      chk("done releases", int'(irq_busy), 0);

      // Ack coincides with a fresh request of the winning bit
      cycle(0, 5'b00100, 1, 0, 0, 0, 16'h0000, 8'h00);
      chk("timer vector", int'(irq_vector), 16'h0050);
      peek("IF[2] kept", 16'hFF0F, 8'hF4);
      done();

      // Ack with nothing enabled
      wr(16'hFFFF, 8'h00);
      ack();
      chk("null vector", int'(irq_vector), 16'h0000);
      chk("null busy", int'(irq_busy), 1);
      peek("IF unchanged", 16'hFF0F, 8'hF4);
      pulse_req(5'b00001);
      wr(16'hFFFF, 8'h01);
      chk("pending in GRANT", int'(irq_pending), 1);
      done();

      // Write vs request precedence, IE full width
      cycle(0, 5'b00010, 0, 0, 1, 0, 16'hFF0F, 8'hFF);
      peek("IF write FF", 16'hFF0F, 8'hFF);
      cycle(0, 5'b00010, 0, 0, 1, 0, 16'hFF0F, 8'h00);
      peek("req beats write", 16'hFF0F, 8'hE2);
      wr(16'hFFFF, 8'hA5);
      peek("IE A5", 16'hFFFF, 8'hA5);
      cycle(0, 5'b0, 0, 0, 0, 1, 16'hFFFF, 8'h00);
      peek("unmapped addr", 16'h1234, 8'hFF);

      // Reset abandons a dispatch
      wr(16'hFF0F, 8'h1E);
      ack();
      chk("pre-reset vector", int'(irq_vector), 16'h0050);
      cycle(1, 5'b01000, 0, 1, 1, 0, 16'hFFFF, 8'h3C);
      chk("reset in GRANT busy", int'(irq_busy), 0);
      chk("reset in GRANT vector", int'(irq_vector), 16'h0000);
      peek("reset in GRANT IF", 16'hFF0F, 8'hE0);
      peek("reset in GRANT IE", 16'hFFFF, 8'h00);
      done();

      // Mixed traffic against the model
      for (int i = 0; i < 80; i++) begin
         logic [15:0] a;
         int sel;
         sel = int'($urandom_range(0, 2));
         a = (sel == 0) ? 16'hFF0F : (sel == 1) ? 16'hFFFF : 16'h1234;
         cycle($urandom_range(0, 39) == 0,
               5'($urandom_range(0, 31) & $urandom_range(0, 31) & $urandom_range(0, 31)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
               a, 8'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
